// File: rtl/mac_tx_frame_feeder.sv
// Transmit-side MAC client: buffers one frame from an upstream byte stream and
// replays it to the MAC until the end-of-frame status pulse releases it.
module mac_tx_frame_feeder #(
  parameter int ADDR_W    = 11,
  parameter int MAX_RETRY = 15
) (
  input  logic        tx_mac_clk,
  input  logic        rstn,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  input  logic        in_error,
  output logic        in_ready,
  output logic        tx_mac_valid,
  output logic [7:0]  tx_mac_data,
  output logic        tx_mac_last,
  output logic        tx_mac_error,
  input  logic        tx_mac_ready,
  input  logic        tx_collision,
  input  logic        tx_retransmit,
  input  logic        tx_statistics_valid,
  output logic        busy,
  output logic [15:0] frames_sent,
  output logic [15:0] frames_dropped
);

  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  localparam logic [RW-1:0] MAX_RETRY_C = RW'(MAX_RETRY);

  typedef enum logic [2:0] {LOAD, DISCARD, PREFETCH, SEND, WAIT_STAT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] last_idx_q, last_idx_d;
  logic [RW-1:0]     retry_q, retry_d;
  logic [15:0]       frames_sent_q, frames_sent_d;
  logic [15:0]       frames_dropped_q, frames_dropped_d;
  logic              in_ready_q, in_ready_d;
  logic              tx_mac_valid_q, tx_mac_valid_d;
  logic              tx_mac_last_q, tx_mac_last_d;
  logic              busy_q, busy_d;
  logic [7:0]        tx_mac_data_q;

  logic [7:0]        mem [2**ADDR_W];
  logic              mem_we;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] rd_next;
  logic              wr_hs;
  logic              mac_hs;
  logic              drop_inc;
  logic              sent_inc;
  logic              unused_collision;

  assign unused_collision = tx_collision;
  assign wr_hs   = in_valid && in_ready_q;
  assign mac_hs  = tx_mac_valid_q && tx_mac_ready;
  assign rd_next = rd_ptr_q + 1'b1;

  always_comb begin
    state_d          = state_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    last_idx_d       = last_idx_q;
    retry_d          = retry_q;
    frames_sent_d    = frames_sent_q;
    frames_dropped_d = frames_dropped_q;
    tx_mac_last_d    = tx_mac_last_q;
    mem_we           = 1'b0;
    rd_en            = 1'b0;
    rd_addr          = rd_ptr_q;
    drop_inc         = 1'b0;
    sent_inc         = 1'b0;

    case (state_q)
      LOAD: begin
        if (wr_hs) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (in_last) begin
            last_idx_d = wr_ptr_q;
            wr_ptr_d   = '0;
            if (in_error) begin
              drop_inc = 1'b1;
            end else begin
              state_d  = PREFETCH;
              rd_ptr_d = '0;
              retry_d  = '0;
            end
          end else if (wr_ptr_q == {ADDR_W{1'b1}}) begin
            state_d  = DISCARD;
            wr_ptr_d = '0;
          end
        end
      end

      DISCARD: begin
        if (wr_hs && in_last) begin
          drop_inc = 1'b1;
          wr_ptr_d = '0;
          state_d  = LOAD;
        end
      end

      PREFETCH: begin
        rd_en         = 1'b1;
        rd_addr       = rd_ptr_q;
        tx_mac_last_d = (rd_ptr_q == last_idx_q);
        state_d       = SEND;
      end

      SEND, WAIT_STAT: begin
        // A replay request wins over both the final handshake and the release pulse
        if (tx_retransmit) begin
          if (retry_q < MAX_RETRY_C) begin
            retry_d  = retry_q + 1'b1;
            rd_ptr_d = '0;
            state_d  = PREFETCH;
          end else begin
            drop_inc = 1'b1;
            wr_ptr_d = '0;
            state_d  = LOAD;
          end
        end else if (state_q == SEND) begin
          if (mac_hs) begin
            if (tx_mac_last_q) begin
              state_d = WAIT_STAT;
            end else begin
              rd_ptr_d      = rd_next;
              rd_en         = 1'b1;
              rd_addr       = rd_next;
              tx_mac_last_d = (rd_next == last_idx_q);
            end
          end
        end else if (tx_statistics_valid) begin
          sent_inc = 1'b1;
          wr_ptr_d = '0;
          state_d  = LOAD;
        end
      end

      default: state_d = LOAD;
    endcase

    if (state_d != SEND) tx_mac_last_d = 1'b0;
    if (drop_inc && frames_dropped_q != 16'hFFFF) frames_dropped_d = frames_dropped_q + 16'd1;
    if (sent_inc && frames_sent_q != 16'hFFFF) frames_sent_d = frames_sent_q + 16'd1;

    in_ready_d     = (state_d == LOAD) || (state_d == DISCARD);
    busy_d         = (state_d != LOAD);
    tx_mac_valid_d = (state_d == SEND);
  end

  always_ff @(posedge tx_mac_clk) begin
    if (mem_we) mem[wr_ptr_q] <= in_data;
  end

  always_ff @(posedge tx_mac_clk or negedge rstn) begin
    if (!rstn) begin
      state_q          <= LOAD;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      last_idx_q       <= '0;
      retry_q          <= '0;
      frames_sent_q    <= '0;
      frames_dropped_q <= '0;
      in_ready_q       <= 1'b1;
      tx_mac_valid_q   <= 1'b0;
      tx_mac_last_q    <= 1'b0;
      busy_q           <= 1'b0;
      tx_mac_data_q    <= 8'h00;
    end else begin
      state_q          <= state_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      last_idx_q       <= last_idx_d;
      retry_q          <= retry_d;
      frames_sent_q    <= frames_sent_d;
      frames_dropped_q <= frames_dropped_d;
      in_ready_q       <= in_ready_d;
      tx_mac_valid_q   <= tx_mac_valid_d;
      tx_mac_last_q    <= tx_mac_last_d;
      busy_q           <= busy_d;
      if (rd_en) tx_mac_data_q <= mem[rd_addr];
    end
  end

  assign in_ready       = in_ready_q;
  assign tx_mac_valid   = tx_mac_valid_q;
  assign tx_mac_data    = tx_mac_data_q;
  assign tx_mac_last    = tx_mac_last_q;
  assign tx_mac_error   = 1'b0;
  assign busy           = busy_q;
  assign frames_sent    = frames_sent_q;
  assign frames_dropped = frames_dropped_q;

endmodule

// File: tb/tb_mac_tx_frame_feeder.sv
// Directed bench for mac_tx_frame_feeder: load, send, backpressure, replay,
// retry exhaustion, oversize discard, errored frames and mid-frame reset.
module tb_mac_tx_frame_feeder;

  logic        tx_mac_clk;
  logic        rstn;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_error;
  logic        in_ready;
  logic        tx_mac_valid;
  logic [7:0]  tx_mac_data;
  logic        tx_mac_last;
  logic        tx_mac_error;
  logic        tx_mac_ready;
  logic        tx_collision;
  logic        tx_retransmit;
  logic        tx_statistics_valid;
  logic        busy;
  logic [15:0] frames_sent;
  logic [15:0] frames_dropped;

  int testsRun = 0;
  int testsFailed = 0;

  mac_tx_frame_feeder #(.ADDR_W(11), .MAX_RETRY(15)) dut (
    .tx_mac_clk          (tx_mac_clk),
    .rstn                (rstn),
    .in_valid            (in_valid),
    .in_data             (in_data),
    .in_last             (in_last),
    .in_error            (in_error),
    .in_ready            (in_ready),
    .tx_mac_valid        (tx_mac_valid),
    .tx_mac_data         (tx_mac_data),
    .tx_mac_last         (tx_mac_last),
    .tx_mac_error        (tx_mac_error),
    .tx_mac_ready        (tx_mac_ready),
    .tx_collision        (tx_collision),
    .tx_retransmit       (tx_retransmit),
    .tx_statistics_valid (tx_statistics_valid),
    .busy                (busy),
    .frames_sent         (frames_sent),
    .frames_dropped      (frames_dropped)
  );

  initial tx_mac_clk = 1'b0;
  always #5 tx_mac_clk = ~tx_mac_clk;

  task automatic step();
    @(posedge tx_mac_clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Pushes len bytes base, base+1, ... ; returns one cycle after the last handshake
  task automatic applyStimulus(input int len, input logic [7:0] base, input logic err);
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      b        = base + 8'(i);
      in_valid = 1'b1;
      in_data  = b;
      in_last  = (i == len - 1);
      in_error = err && (i == len - 1);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_error = 1'b0;
  endtask

  // Starts on the first valid cycle; checks every presented byte against its index
  task automatic receiveFrame(input string tag, input int len, input logic [7:0] base,
                              input logic randomReady, output int cycles);
    int idx;
    logic rdy;
    logic [7:0] expByte;
    idx = 0;
    cycles = 0;
    while (idx < len && cycles < 2000) begin
      rdy = randomReady ? 1'($urandom_range(0, 1)) : 1'b1;
      tx_mac_ready = rdy;
      if (tx_mac_valid) begin
        expByte = base + 8'(idx);
        checkOutput({tag, "_data"}, 32'(tx_mac_data), 32'(expByte));
        checkOutput({tag, "_last"}, 32'(tx_mac_last), 32'(idx == len - 1));
        if (rdy) idx++;
      end
      step();
      cycles++;
    end
    tx_mac_ready = 1'b0;
    checkOutput({tag, "_count"}, 32'(idx), 32'(len));
    checkOutput({tag, "_valid_after"}, 32'(tx_mac_valid), 32'd0);
  endtask

  task automatic pulseStat();
    tx_statistics_valid = 1'b1;
    step();
    tx_statistics_valid = 1'b0;
  endtask

  initial begin
    int cycles;
    rstn = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    in_last = 1'b0;
    in_error = 1'b0;
    tx_mac_ready = 1'b0;
    tx_collision = 1'b0;
    tx_retransmit = 1'b0;
    tx_statistics_valid = 1'b0;
    #2 rstn = 1'b0;
    step();
    step();
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_valid", 32'(tx_mac_valid), 32'd0);
    checkOutput("rst_last", 32'(tx_mac_last), 32'd0);
    checkOutput("rst_error", 32'(tx_mac_error), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_data", 32'(tx_mac_data), 32'h00);
    checkOutput("rst_sent", 32'(frames_sent), 32'd0);
    checkOutput("rst_dropped", 32'(frames_dropped), 32'd0);
    @(negedge tx_mac_clk);
    rstn = 1'b1;
    step();

    // 64-byte frame, ready held high
    applyStimulus(64, 8'h00, 1'b0);
    checkOutput("f64_in_ready_n1", 32'(in_ready), 32'd0);
    checkOutput("f64_valid_n1", 32'(tx_mac_valid), 32'd0);
    checkOutput("f64_busy_n1", 32'(busy), 32'd1);
    step();
    checkOutput("f64_valid_n2", 32'(tx_mac_valid), 32'd1);
    receiveFrame("f64", 64, 8'h00, 1'b0, cycles);
    checkOutput("f64_cycles", 32'(cycles), 32'd64);
    pulseStat();
    checkOutput("f64_in_ready_m1", 32'(in_ready), 32'd1);
    checkOutput("f64_sent", 32'(frames_sent), 32'd1);
    checkOutput("f64_busy_m1", 32'(busy), 32'd0);

    // 100-byte frame under random backpressure
    applyStimulus(100, 8'h40, 1'b0);
    step();
    receiveFrame("f100", 100, 8'h40, 1'b1, cycles);
    pulseStat();
    checkOutput("f100_sent", 32'(frames_sent), 32'd2);

    // 60-byte frame, replay requested while byte 21 is presented
    applyStimulus(60, 8'h10, 1'b0);
    step();
    tx_mac_ready = 1'b1;
    for (int i = 0; i <= 20; i++) begin
      checkOutput("rtx_pre_data", 32'(tx_mac_data), 32'(8'h10 + 8'(i)));
      step();
    end
    tx_mac_ready = 1'b0;
    checkOutput("rtx_byte21", 32'(tx_mac_data), 32'h25);
    tx_retransmit = 1'b1;
    step();
    tx_retransmit = 1'b0;
    checkOutput("rtx_valid_m1", 32'(tx_mac_valid), 32'd0);
    step();
    checkOutput("rtx_valid_m2", 32'(tx_mac_valid), 32'd1);
    checkOutput("rtx_data_m2", 32'(tx_mac_data), 32'h10);
    receiveFrame("rtx", 60, 8'h10, 1'b0, cycles);
    pulseStat();
    checkOutput("rtx_sent", 32'(frames_sent), 32'd3);

    // Sixteen replay requests: fifteen accepted, the last drops the frame
    applyStimulus(8, 8'h80, 1'b0);
    step();
    for (int r = 1; r <= 16; r++) begin
      tx_retransmit = 1'b1;
      step();
      tx_retransmit = 1'b0;
      if (r < 16) begin
        checkOutput("retry_valid_low", 32'(tx_mac_valid), 32'd0);
        step();
        checkOutput("retry_valid_high", 32'(tx_mac_valid), 32'd1);
        checkOutput("retry_byte0", 32'(tx_mac_data), 32'h80);
      end
    end
    checkOutput("retry_in_ready", 32'(in_ready), 32'd1);
    checkOutput("retry_dropped", 32'(frames_dropped), 32'd1);
    checkOutput("retry_busy", 32'(busy), 32'd0);
    checkOutput("retry_valid_end", 32'(tx_mac_valid), 32'd0);
    checkOutput("retry_sent", 32'(frames_sent), 32'd3);

    // Oversize: 2049 bytes without in_last, then a closing byte
    for (int i = 0; i < 2050; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      in_last  = (i == 2049);
      step();
      if (i == 2047) begin
        checkOutput("ovf_busy_discard", 32'(busy), 32'd1);
        checkOutput("ovf_in_ready_discard", 32'(in_ready), 32'd1);
      end
      if (tx_mac_valid) checkOutput("ovf_no_send", 32'(tx_mac_valid), 32'd0);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    step();
    checkOutput("ovf_dropped", 32'(frames_dropped), 32'd2);
    checkOutput("ovf_busy", 32'(busy), 32'd0);
    checkOutput("ovf_valid", 32'(tx_mac_valid), 32'd0);

    // Single-byte frame
    applyStimulus(1, 8'hA5, 1'b0);
    checkOutput("one_valid_n1", 32'(tx_mac_valid), 32'd0);
    step();
    checkOutput("one_valid_n2", 32'(tx_mac_valid), 32'd1);
    checkOutput("one_data", 32'(tx_mac_data), 32'hA5);
    checkOutput("one_last", 32'(tx_mac_last), 32'd1);
    tx_mac_ready = 1'b1;
    step();
    tx_mac_ready = 1'b0;
    checkOutput("one_valid_after", 32'(tx_mac_valid), 32'd0);
    pulseStat();
    checkOutput("one_sent", 32'(frames_sent), 32'd4);

    // Errored frame is dropped without leaving LOAD
    applyStimulus(5, 8'h55, 1'b1);
    checkOutput("err_in_ready", 32'(in_ready), 32'd1);
    checkOutput("err_busy", 32'(busy), 32'd0);
    checkOutput("err_dropped", 32'(frames_dropped), 32'd3);
    step();
    checkOutput("err_no_send", 32'(tx_mac_valid), 32'd0);

    // Reset asserted mid-SEND, then a fresh frame
    applyStimulus(10, 8'h30, 1'b0);
    step();
    tx_mac_ready = 1'b1;
    step();
    step();
    step();
    checkOutput("rst_mid_data", 32'(tx_mac_data), 32'h33);
    rstn = 1'b0;
    #1;
    checkOutput("arst_valid", 32'(tx_mac_valid), 32'd0);
    checkOutput("arst_last", 32'(tx_mac_last), 32'd0);
    checkOutput("arst_data", 32'(tx_mac_data), 32'h00);
    checkOutput("arst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("arst_busy", 32'(busy), 32'd0);
    checkOutput("arst_sent", 32'(frames_sent), 32'd0);
    checkOutput("arst_dropped", 32'(frames_dropped), 32'd0);
    tx_mac_ready = 1'b0;
    @(negedge tx_mac_clk);
    rstn = 1'b1;
    step();
    applyStimulus(3, 8'hC0, 1'b0);
    step();
    checkOutput("post_valid", 32'(tx_mac_valid), 32'd1);
    receiveFrame("post", 3, 8'hC0, 1'b0, cycles);
    pulseStat();
    checkOutput("post_sent", 32'(frames_sent), 32'd1);
    checkOutput("post_error_tied", 32'(tx_mac_error), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/mac_tx_frame_feeder.md
# mac_tx_frame_feeder

Transmit-side client of the triple-speed Ethernet MAC. It buffers one complete frame from an upstream byte stream, then drives the MAC client TX interface (tx_mac_valid/data/last, tx_mac_ready). It holds the frame until the MAC reports completion, so it can replay the frame when the MAC requests a retransmit. It is the counterpart of the existing RX-side MAC hookup and lives in the tx_mac_clk domain.

## Interface
- ADDR_W, 11: frame buffer address width; capacity 2^ADDR_W bytes (2048 holds a 1518-byte frame).
- MAX_RETRY, 15: retransmit requests accepted per frame before the frame is dropped.

- tx_mac_clk  input  1  single clock for all logic (MAC TX client clock).
- rstn  input  1  reset, asynchronous, active-low.
- in_valid  input  1  upstream byte valid.
- in_data  input  8  upstream byte.
- in_last  input  1  final byte of the frame.
- in_error  input  1  upstream frame bad; sampled with in_last.
- in_ready  output  1  feeder accepts a byte this cycle.
- tx_mac_valid  output  1  byte valid to the MAC.
- tx_mac_data  output  8  byte to the MAC.
- tx_mac_last  output  1  final byte of the frame.
- tx_mac_error  output  1  tied 0; bad frames are never sent.
- tx_mac_ready  input  1  MAC accepts the current byte.
- tx_collision  input  1  MAC collision indication; status only, no action taken.
- tx_retransmit  input  1  MAC requests a replay of the current frame (single-cycle pulse).
- tx_statistics_valid  input  1  MAC end-of-frame status pulse; releases the held frame.
- busy  output  1  high in every state except LOAD.
- frames_sent  output  16  frames released by tx_statistics_valid; saturates at 16'hFFFF.
- frames_dropped  output  16  oversize, in_error, or retry-exhausted frames; saturates.

## Operation
- A write handshake is in_valid && in_ready. A MAC handshake is tx_mac_valid && tx_mac_ready.
- States: LOAD, DISCARD, PREFETCH, SEND, WAIT_STAT.
- LOAD:
  - in_ready = 1. Each write handshake stores in_data at wr_ptr and increments wr_ptr.
  - Write handshake with in_last: latch len = wr_ptr+1.
    - If in_error is high, the frame is dropped (frames_dropped++) and the state stays LOAD with wr_ptr cleared.
    - Otherwise go to PREFETCH with rd_ptr=0 and retry=0.
  - Write handshake on the byte at address 2^ADDR_W-1 without in_last: go to DISCARD.
- DISCARD:
  - in_ready = 1; bytes are consumed and not stored.
  - Write handshake with in_last: frames_dropped++, go to LOAD with wr_ptr=0.
- PREFETCH: one cycle for the synchronous RAM read of rd_ptr; tx_mac_valid = 0. Next state is SEND.
- SEND:
  - tx_mac_valid = 1, tx_mac_data = buf[rd_ptr], tx_mac_last = (rd_ptr == len-1).
  - Data stays stable while tx_mac_ready is low.
  - On a MAC handshake, the next byte is presented in the following cycle with no bubble; the next byte is prefetched ahead.
  - Handshake on the last byte: go to WAIT_STAT.
- WAIT_STAT:
  - tx_mac_valid = 0.
  - tx_statistics_valid: frames_sent++, wr_ptr=0, go to LOAD.
- tx_retransmit in SEND or WAIT_STAT:
  - If retry < MAX_RETRY: retry++, rd_ptr=0, go to PREFETCH.
  - Otherwise: frames_dropped++, go to LOAD.
  - tx_retransmit takes priority over a simultaneous last-byte handshake and over a simultaneous tx_statistics_valid.
- tx_retransmit in LOAD, DISCARD or PREFETCH is ignored.
- A frame of length 1 is legal: its single byte carries tx_mac_last.

## Timing
- Reset values: state LOAD; in_ready 1; tx_mac_valid, tx_mac_last, tx_mac_error, busy all 0; tx_mac_data 8'h00; both counters 0; pointers and retry 0.
- Assertion of rstn mid-frame abandons the frame immediately. The MAC sees tx_mac_valid fall without tx_mac_last.
- All outputs are registered.
- A last write handshake at cycle N gives:
  - in_ready low from N+1;
  - PREFETCH at N+1;
  - tx_mac_valid high at N+2.
- With tx_mac_ready held high, a frame of len bytes occupies exactly len consecutive valid cycles.
- tx_statistics_valid at cycle M gives in_ready high at M+1; counters update at M+1.
- tx_retransmit at cycle M gives tx_mac_valid low at M+1 and byte 0 presented again at M+2.

## Test plan
- Load a 64-byte frame of 0x00..0x3F with tx_mac_ready tied 1 -> valid high 2 cycles after in_last; 64 bytes appear in order; last flagged on 0x3F; frames_sent=1 after the stat pulse.
- Toggle tx_mac_ready pseudo-randomly on a 100-byte frame -> data held stable while ready is low; no byte lost or duplicated.
- Pulse tx_retransmit after byte 20 of a 60-byte frame -> replay starts from byte 0 at M+2; the full 60 bytes are then sent; frames_sent=1.
- Issue 16 retransmits with MAX_RETRY=15 -> the 16th drops the frame; frames_dropped=1; in_ready high at the next cycle.
- Send 2049 bytes without in_last, then in_last -> nothing sent; frames_dropped=1. Then a 1-byte frame 0xA5 -> single byte with tx_mac_last=1.
- Assert rstn low during SEND -> all outputs return to their reset values asynchronously; the next frame loads and sends normally.
